// File: rtl/cpu_sequencer_if.sv
// Bus between the CPU sequencer and its surroundings: the run control,
// the instruction-memory fetch handshake, the ALU/accumulator controls
// and the status flags.
interface cpu_sequencer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid;
    logic [DATA_W-1:0] imem_data;
    logic [1:0]        alu_op;
    logic [3:0]        alu_operand;
    logic              acc_we;
    logic              retire;
    logic [ADDR_W-1:0] pc_out;
    logic              halted;
    logic              err;

    // The sequencer side
    modport master (
        input  start, imem_valid, imem_data,
        output imem_req, imem_addr, alu_op, alu_operand,
               acc_we, retire, pc_out, halted, err
    );

    // The memory / datapath / run-control side
    modport slave (
        output start, imem_valid, imem_data,
        input  imem_req, imem_addr, alu_op, alu_operand,
               acc_we, retire, pc_out, halted, err
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the simple-ISA CPU. Owns the program counter,
// fetches instructions with a req/valid handshake, decodes the 2-bit opcode
// into ALU/accumulator controls, follows jumps, halts on a jump to itself
// and raises a sticky error when a fetch is never answered.
module cpu_sequencer #(
    parameter int ADDR_W        = 4,
    parameter int DATA_W        = 8,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    cpu_sequencer_if.master   bus
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] HALT   = 3'd4;
    localparam logic [2:0] ERROR  = 3'd5;

    localparam logic [1:0] OP_JUMP       = 2'b11;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(FETCH_TIMEOUT);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [7:0]        timeoutCnt_q, timeoutCnt_d;

    logic [1:0]        opcode;
    logic [3:0]        operand;
    logic [ADDR_W-1:0] jumpTarget;
    logic              isJump;
    logic              selfJump;
    logic              unused_irBits;

    assign opcode        = ir_q[7:6];
    assign operand       = ir_q[3:0];
    assign unused_irBits = ^ir_q[5:4];
    assign jumpTarget    = ADDR_W'(operand);
    assign isJump        = (opcode == OP_JUMP);
    assign selfJump      = isJump && (jumpTarget == pc_q);

    // Next-state logic: sequencing, instruction capture, pc update, fetch timeout
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        timeoutCnt_d = timeoutCnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d      = FETCH;
                    timeoutCnt_d = '0;
                end
            end
            FETCH: begin
                if (bus.imem_valid) begin
                    ir_d    = bus.imem_data;
                    state_d = DECODE;
                end else begin
                    timeoutCnt_d = timeoutCnt_q + 8'd1;
                    if (timeoutCnt_d == TIMEOUT_LIMIT) begin
                        state_d = ERROR;
                    end
                end
            end
            DECODE: begin
                state_d = EXEC;
            end
            EXEC: begin
                if (selfJump) begin
                    state_d = HALT;
                end else begin
                    pc_d         = isJump ? jumpTarget : pc_q + ADDR_W'(1);
                    state_d      = FETCH;
                    timeoutCnt_d = '0;
                end
            end
            HALT:    state_d = HALT;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            ir_q         <= '0;
            timeoutCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            timeoutCnt_q <= timeoutCnt_d;
        end
    end

    assign bus.imem_req    = (state_q == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.pc_out      = pc_q;
    assign bus.alu_op      = opcode;
    assign bus.alu_operand = operand;
    assign bus.acc_we      = (state_q == EXEC) && !isJump;
    assign bus.retire      = (state_q == EXEC) && !selfJump;
    assign bus.halted      = (state_q == HALT);
    assign bus.err         = (state_q == ERROR);

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the simple-ISA CPU. It owns the 4-bit program counter and fetches 8-bit instructions from instruction memory with a req/valid handshake. It decodes the 2-bit opcode and drives the ALU/accumulator controls. It handles branches, halts on a self-jump, and flags an error on a fetch timeout.

Parameters:
ADDR_W, 4, program-counter and instruction-address width
DATA_W, 8, instruction width; opcode = instr[7:6], operand = instr[3:0], instr[5:4] ignored
FETCH_TIMEOUT, 15, consecutive FETCH cycles without imem_valid before entering ERROR (1..255)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  level; begins execution when sampled high in IDLE
imem_req  out  1  fetch request, high only in FETCH
imem_addr  out  ADDR_W  fetch address, equals pc
imem_valid  in  1  instruction valid, sampled in FETCH; may be combinational off imem_req
imem_data  in  DATA_W  instruction, captured when imem_req && imem_valid
alu_op  out  2  opcode of current instruction (00 ADD, 01 SUB, 10 LOAD, 11 JUMP)
alu_operand  out  4  operand of current instruction
acc_we  out  1  accumulator write strobe, one cycle in EXEC for opcodes 00/01/10
retire  out  1  one-cycle pulse per completed instruction
pc_out  out  ADDR_W  current program counter
halted  out  1  sticky, self-jump executed
err  out  1  sticky, fetch timeout

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; pc=0; ir=0; timeout count=0. All outputs read 0 (imem_req, acc_we, retire, halted, err, alu_op, alu_operand, pc_out, imem_addr). Reset overrides every other input, including mid-instruction; an aborted instruction produces no acc_we and no retire.
- States: IDLE, FETCH, DECODE, EXEC, HALT, ERROR.
- IDLE: start=1 -> FETCH. Otherwise stay.
- FETCH: imem_req=1, imem_addr=pc.
  - If imem_valid=1: ir<=imem_data; next state DECODE.
  - Otherwise increment timeout count. When it reaches FETCH_TIMEOUT -> ERROR.
  - Count clears on every entry to FETCH.
  - imem_addr stays stable while waiting.
- DECODE: one cycle. alu_op/alu_operand driven from ir from DECODE onward (held until the next ir load). No strobes.
- EXEC (one cycle):
  - Opcodes 00/01/10: acc_we=1, retire=1, pc<=pc+1 mod 2^ADDR_W (15 -> 0); next state FETCH.
  - Opcode 11 with operand != pc: pc<=operand, retire=1, acc_we=0; next state FETCH.
  - Opcode 11 with operand == pc: pc unchanged, retire=0, acc_we=0; next state HALT.
- HALT: halted=1, sticky until reset. imem_req=0; start ignored.
- ERROR: err=1, sticky until reset. imem_req=0; pc frozen; start ignored.
- start is examined only in IDLE. Deasserting start mid-run has no effect.
- imem_data/imem_valid are ignored outside FETCH.
- Latency with zero-wait memory: 3 cycles per instruction (FETCH, DECODE, EXEC). Each memory wait cycle adds 1.
- pc_out is the registered pc; its update is visible in the cycle after EXEC.

Test Plan:
- Release reset, start=1, zero-wait memory with 0:0x85, 1:0x03, 2:0xC2 -> acc_we with (alu_op=10, operand=5) 3 cycles after FETCH entry, then (00, 3) 3 cycles later; halted=1 with pc_out=2 after third instruction; exactly 2 retire pulses.
- Memory filled with 0x01 (ADD 1), run 16+ instructions -> imem_addr sequence 0..15 then 0 (wrap); retire every 3 cycles.
- pc=3 holding 0xC9 -> next imem_addr=9, acc_we=0, retire=1.
- imem_valid delayed 4 cycles on one fetch -> imem_req held 5 cycles, imem_addr constant, DECODE entered only after valid, no spurious acc_we.
- imem_valid never asserted -> err=1 after exactly 15 FETCH cycles, imem_req=0, pc frozen; start toggling has no effect until reset.
- reset=0 asserted during EXEC of 0x85 -> next cycle IDLE, pc_out=0, acc_we=0, retire=0, halted/err cleared.
